// File: rtl/aer_spike_encoder_if.sv
// aer_spike_encoder_if: AER word handshake from the spike encoder to the router.
// The encoder drives the word and its valid flag; the router answers with ready.
interface aer_spike_encoder_if #(
  parameter int AER_BIT_WIDTH = 32
);
  logic [AER_BIT_WIDTH-1:0] aerData_o;
  logic                     aerValid_o;
  logic                     aerReady_i;

  modport master (output aerData_o, output aerValid_o, input aerReady_i);
  modport slave  (input aerData_o, input aerValid_o, output aerReady_i);
endinterface

// File: rtl/aer_spike_encoder.sv
// aer_spike_encoder: transmit end of the spike path. Spikes tagged with the neuron
// index are queued in a FIFO during a time step and sent to the router as AER words.
// A one-cycle tickDone_o marks the point where every spike of the step has been handed off.
// Optional feature: define AER_TIMESTAMP_EN to add an 8-bit tick counter field to each word
// at bits [NURN+CORE+7:NURN+CORE]; without it those bits are 0.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for tickStart_i, no spikes accepted
// COLLECT | time step running, spikes pushed into the FIFO
// DRAIN   | step evaluated, waiting for FIFO and output stage to empty
// DONE    | one cycle, tickDone_o asserted
module aer_spike_encoder #(
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int CORE_ADDR_WIDTH    = 8,
  parameter int AER_BIT_WIDTH      = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int FIFO_PTR_WIDTH     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          outSpike_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0] nurnIdx_i,
  input  logic [CORE_ADDR_WIDTH-1:0]    coreAddr_i,
  input  logic                          tickStart_i,
  input  logic                          tickEnd_i,
  aer_spike_encoder_if.master           aer,
  output logic                          tickDone_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [FIFO_PTR_WIDTH:0]       fifoCount_o
);

  localparam int NC = NURN_CNT_BIT_WIDTH + CORE_ADDR_WIDTH;
  localparam logic [FIFO_PTR_WIDTH:0]   CNT_ONE  = (FIFO_PTR_WIDTH+1)'(1);
  localparam logic [FIFO_PTR_WIDTH:0]   CNT_FULL = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_WIDTH-1:0] PTR_ONE  = FIFO_PTR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t state, stateNext;

  logic [AER_BIT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wrPtr, rdPtr;
  logic [AER_BIT_WIDTH-1:0]  pushWord;
  logic                      fifoEmpty, fifoFull;
  logic                      pushReq, pushOk, popEn, startAccept;

`ifdef AER_TIMESTAMP_EN
  logic [7:0] tickCnt;

  // Tick counter: one increment per completed step, natural 8-bit wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)           tickCnt <= '0;
    else if (state == DONE) tickCnt <= tickCnt + 8'd1;
  end
`endif

  assign fifoEmpty   = (fifoCount_o == '0);
  assign fifoFull    = (fifoCount_o == CNT_FULL);
  assign startAccept = (state == IDLE) && tickStart_i;
  // COLLECT covers the tickEnd_i cycle too, since the state only leaves on the edge after it.
  assign pushReq     = outSpike_i && (state == COLLECT);
  assign popEn       = !fifoEmpty && (!aer.aerValid_o || aer.aerReady_i);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign pushOk      = pushReq && (!fifoFull || popEn);

  // AER word assembly: neuron index low, core address above, optional timestamp above that.
  always_comb begin
    pushWord = '0;
    pushWord[NURN_CNT_BIT_WIDTH-1:0] = nurnIdx_i;
    pushWord[NC-1:NURN_CNT_BIT_WIDTH] = coreAddr_i;
`ifdef AER_TIMESTAMP_EN
    pushWord[NC+7:NC] = tickCnt;
`endif
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    stateNext  = state;
    tickDone_o = 1'b0;
    busy_o     = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (tickStart_i) stateNext = COLLECT;
      end
      COLLECT: if (tickEnd_i) stateNext = DRAIN;
      // Leave only once the output register itself has been emptied, so tickDone_o
      // follows the cycle in which aerValid_o is already low.
      DRAIN: if (fifoEmpty && !aer.aerValid_o) stateNext = DONE;
      DONE: begin
        tickDone_o = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // FIFO storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (pushOk) mem[wrPtr] <= pushWord;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount_o <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (popEn)  rdPtr <= rdPtr + PTR_ONE;
      case ({pushOk, popEn})
        2'b10:   fifoCount_o <= fifoCount_o + CNT_ONE;
        2'b01:   fifoCount_o <= fifoCount_o - CNT_ONE;
        default: fifoCount_o <= fifoCount_o;
      endcase
    end
  end

  // Sticky drop flag, cleared only when a new step is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                        overflow_o <= 1'b0;
    else if (startAccept)                overflow_o <= 1'b0;
    else if (pushReq && fifoFull && !popEn) overflow_o <= 1'b1;
  end

  // Output stage: refill from the FIFO head whenever the current word is gone or leaving.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      aer.aerData_o  <= '0;
      aer.aerValid_o <= 1'b0;
    end else if (popEn) begin
      aer.aerData_o  <= mem[rdPtr];
      aer.aerValid_o <= 1'b1;
    end else if (aer.aerReady_i) begin
      aer.aerValid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// tb_aer_spike_encoder: directed stimulus with a scoreboard queue of expected AER words
// and a negedge monitor comparing every presented word against the queue head.
module tb_aer_spike_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       outSpike = 1'b0;
  logic [7:0] nurnIdx = '0;
  logic [7:0] coreAddr = 8'h05;
  logic       tickStart = 1'b0;
  logic       tickEnd = 1'b0;
  logic       tickDone, busy, overflow;
  logic [4:0] fifoCount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastHs = 0;
  int doneCount = 0;
  int tsExp = 0;
  logic [31:0] expQ[$];

  aer_spike_encoder_if #(.AER_BIT_WIDTH(32)) aerIf ();

  aer_spike_encoder dut (
    .clk_i(clk), .rst_n_i(rst_n), .outSpike_i(outSpike), .nurnIdx_i(nurnIdx),
    .coreAddr_i(coreAddr), .tickStart_i(tickStart), .tickEnd_i(tickEnd),
    .aer(aerIf), .tickDone_o(tickDone), .busy_o(busy), .overflow_o(overflow),
    .fifoCount_o(fifoCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkWord(input int idx);
    logic [31:0] w;
    w = 32'h0;
    w[7:0]  = idx[7:0];
    w[15:8] = coreAddr;
`ifdef AER_TIMESTAMP_EN
    w[23:16] = tsExp[7:0];
`endif
    return w;
  endfunction

  // Monitor: compare presented words with the scoreboard, retire on handshake.
  always @(negedge clk) begin
    if (tickDone) doneCount++;
    if (aerIf.aerValid_o) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", aerIf.aerData_o);
      end else begin
        chk("aerData", aerIf.aerData_o, expQ[0]);
        if (aerIf.aerReady_i) begin
          void'(expQ.pop_front());
          lastHs = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input int idx, input bit expectPush);
    outSpike = 1'b1;
    nurnIdx  = idx[7:0];
    if (expectPush) expQ.push_back(mkWord(idx));
    step();
    outSpike = 1'b0;
  endtask

  task automatic startTick();
    tickStart = 1'b1;
    step();
    tickStart = 1'b0;
  endtask

  task automatic endTick();
    tickEnd = 1'b1;
    step();
    tickEnd = 1'b0;
  endtask

  // Bounded wait for tickDone_o; returns at the negedge of the DONE cycle.
  task automatic waitDone(input string nm, output int atCyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!tickDone && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tickDone) begin
      errors++;
      $display("FAIL %s: tickDone_o got 0 expected 1 within 300 cycles", nm);
    end else begin
      tsExp++;
    end
    atCyc = cyc;
  endtask

  // After DONE: tickDone_o is a single pulse and busy_o drops.
  task automatic checkAfterDone(input string nm);
    @(negedge clk);
    chk({nm, "_busy_fall"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done_pulse"}, {31'b0, tickDone}, 32'd0);
  endtask

  initial begin
    int atCyc;
    int doneBefore;
    aerIf.aerReady_i = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", {31'b0, aerIf.aerValid_o}, 32'd0);
    chk("rst_data", aerIf.aerData_o, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_count", {27'b0, fifoCount}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_done", {31'b0, tickDone}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Backpressure: three spikes held behind aerReady_i=0
    startTick();
    spike(1, 1'b1);
    spike(2, 1'b1);
    spike(3, 1'b1);
    endTick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, aerIf.aerValid_o}, 32'd1);
      chk("bp_hold", aerIf.aerData_o, 32'h0000_0501);
      step();
    end
    aerIf.aerReady_i = 1'b1;
    waitDone("bp_done", atCyc);
    checkAfterDone("bp");
    chk("bp_empty", expQ.size(), 32'd0);

    // Drain: four spikes queued, tickEnd_i together with aerReady_i going high
    step();
    aerIf.aerReady_i = 1'b0;
    startTick();
    spike(8'h11, 1'b1);
    spike(8'h12, 1'b1);
    spike(8'h13, 1'b1);
    spike(8'h14, 1'b1);
    aerIf.aerReady_i = 1'b1;
    endTick();
    waitDone("drain_done", atCyc);
    // last handshake cycle -> aerValid_o low next cycle -> DONE the cycle after
    chk("drain_done_cycle", atCyc, lastHs + 2);
    checkAfterDone("drain");

    // Overflow: 20 spikes against a stalled router, 17 retained
    step();
    aerIf.aerReady_i = 1'b0;
    startTick();
    for (int i = 0; i < 20; i++) spike(8'h40 + i, i < 17);
    @(negedge clk);
    chk("ovf_count", {27'b0, fifoCount}, 32'd16);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    step();
    aerIf.aerReady_i = 1'b1;
    endTick();
    waitDone("ovf_done", atCyc);
    checkAfterDone("ovf");
    chk("ovf_sticky_idle", {31'b0, overflow}, 32'd1);
    chk("ovf_words", expQ.size(), 32'd0);

    // Stray spikes: in IDLE, and in DRAIN after tickEnd_i; the tickEnd_i cycle itself pushes
    step();
    spike(8'h20, 1'b0);
    step();
    step();
    @(negedge clk);
    chk("stray_idle_count", {27'b0, fifoCount}, 32'd0);
    chk("stray_idle_valid", {31'b0, aerIf.aerValid_o}, 32'd0);
    step();
    startTick();
    @(negedge clk);
    chk("ovf_clear", {31'b0, overflow}, 32'd0);
    chk("start_busy", {31'b0, busy}, 32'd1);
    step();
    tickEnd = 1'b1;
    spike(9, 1'b1);
    tickEnd = 1'b0;
    spike(10, 1'b0);
    waitDone("stray_done", atCyc);
    chk("stray_count", {27'b0, fifoCount}, 32'd0);
    checkAfterDone("stray");

    // Same-cycle tickStart_i+tickEnd_i in IDLE only enters COLLECT
    step();
    doneBefore = doneCount;
    tickStart = 1'b1;
    tickEnd   = 1'b1;
    step();
    tickStart = 1'b0;
    tickEnd   = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("both_busy", {31'b0, busy}, 32'd1);
    chk("both_no_done", doneCount, doneBefore);
    step();
    endTick();
    waitDone("both_done", atCyc);
    checkAfterDone("both");

    // Reset mid-send: one word in the output stage, three in the FIFO
    step();
    aerIf.aerReady_i = 1'b0;
    startTick();
    spike(1, 1'b1);
    spike(2, 1'b1);
    spike(3, 1'b1);
    spike(4, 1'b1);
    @(negedge clk);
    chk("ms_count", {27'b0, fifoCount}, 32'd3);
    chk("ms_valid", {31'b0, aerIf.aerValid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    tsExp = 0;
    chk("ms_rst_valid", {31'b0, aerIf.aerValid_o}, 32'd0);
    chk("ms_rst_data", aerIf.aerData_o, 32'd0);
    chk("ms_rst_count", {27'b0, fifoCount}, 32'd0);
    chk("ms_rst_busy", {31'b0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    aerIf.aerReady_i = 1'b1;
    doneBefore = doneCount;
    repeat (6) step();
    @(negedge clk);
    chk("ms_no_done", doneCount, doneBefore);
    chk("ms_busy", {31'b0, busy}, 32'd0);
    chk("ms_valid_after", {31'b0, aerIf.aerValid_o}, 32'd0);

    // Three ticks of one spike each (idx 7); timestamp field follows the tick count
    for (int t = 0; t < 3; t++) begin
      step();
      startTick();
      spike(7, 1'b1);
      endTick();
      waitDone("ts_done", atCyc);
      checkAfterDone("ts");
    end
    chk("ts_words", expQ.size(), 32'd0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
